// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MULTU/DIVU sequencer for the Execute stage.
// Runs WIDTH shift-add (multiply) or restoring (divide) iterations, one per
// cycle, owns the HI/LO architectural registers and requests a pipeline stall
// while a result is pending and an instruction in E needs the unit.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mul0_div1_sel,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hilo_rd,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Counter value of the final iteration; cnt is 6 bits so WIDTH <= 63.
   localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Control state
   state_t             state_r, state_s;
   logic [5:0]         cnt_r, cnt_s;
   logic               op_div_r, op_div_s;

   // Datapath state.
   // opnd_r : multiplicand (MULTU) or divisor (DIVU).
   // acc_r  : MULTU -> {partial product, remaining multiplier bits};
   //          DIVU  -> low half shifts dividend bits out / quotient bits in.
   // rem_r  : DIVU partial remainder between iterations (always < divisor).
   logic [WIDTH-1:0]   opnd_r, opnd_s;
   logic [2*WIDTH-1:0] acc_r, acc_s;
   logic [WIDTH-1:0]   rem_r, rem_s;

   // Architectural results
   logic [WIDTH-1:0]   hi_r, hi_s;
   logic [WIDTH-1:0]   lo_r, lo_s;
   logic               dbz_r, dbz_s;

   // Single-iteration datapath results
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_acc_s;
   logic [WIDTH:0]     div_shift_s;
   logic               div_fits_s;
   logic [WIDTH-1:0]   div_rem_s;
   logic [WIDTH-1:0]   div_quo_s;

   // One shift-add multiply step: add multiplicand if the current multiplier
   // bit is set, keep the carry, then shift the whole accumulator right.
   always_comb begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      mul_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
   end

   // One restoring divide step: shift the next dividend bit into the
   // WIDTH+1 bit partial remainder and subtract the divisor if it fits.
   always_comb begin
      div_shift_s = {rem_r, acc_r[WIDTH-1]};
      div_fits_s  = (div_shift_s >= {1'b0, opnd_r});
      // When the divisor fits, the difference is below the divisor, so the
      // low WIDTH bits of the modular subtraction are exact.
      if (div_fits_s) begin
         div_rem_s = div_shift_s[WIDTH-1:0] - opnd_r;
      end else begin
         div_rem_s = div_shift_s[WIDTH-1:0];
      end
      div_quo_s = {acc_r[WIDTH-2:0], div_fits_s};
   end

   // Next-state and datapath update: accept, iterate, complete.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      op_div_s = op_div_r;
      opnd_s   = opnd_r;
      acc_s    = acc_r;
      rem_s    = rem_r;
      hi_s     = hi_r;
      lo_s     = lo_r;
      dbz_s    = dbz_r;

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               op_div_s = mul0_div1_sel;
               cnt_s    = 6'd0;
               dbz_s    = 1'b0;
               rem_s    = {WIDTH{1'b0}};
               if (mul0_div1_sel) begin
                  opnd_s = src_b;
                  acc_s  = {{WIDTH{1'b0}}, src_a};
               end else begin
                  opnd_s = src_a;
                  acc_s  = {{WIDTH{1'b0}}, src_b};
               end
               // Divide by zero skips iteration entirely and commits the
               // architecturally defined result straight away.
               if (mul0_div1_sel && (src_b == {WIDTH{1'b0}})) begin
                  state_s = ST_DONE;
                  hi_s    = src_a;
                  lo_s    = {WIDTH{1'b1}};
                  dbz_s   = 1'b1;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_RUN: begin
            // start is ignored here; the hazard unit re-presents it later.
            cnt_s = cnt_r + 6'd1;
            if (op_div_r) begin
               acc_s = {{WIDTH{1'b0}}, div_quo_s};
               rem_s = div_rem_s;
            end else begin
               acc_s = mul_acc_s;
               rem_s = rem_r;
            end

            if (cnt_r == LAST_CNT) begin
               // Final iteration commits straight into HI/LO.
               state_s = ST_DONE;
               cnt_s   = 6'd0;
               if (op_div_r) begin
                  hi_s = div_rem_s;
                  lo_s = div_quo_s;
               end else begin
                  hi_s = mul_acc_s[2*WIDTH-1:WIDTH];
                  lo_s = mul_acc_s[WIDTH-1:0];
               end
            end else begin
               state_s = ST_RUN;
            end
         end

         default: begin
            state_s = ST_IDLE;
            cnt_s   = 6'd0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 6'd0;
         op_div_r <= 1'b0;
         opnd_r   <= {WIDTH{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
         rem_r    <= {WIDTH{1'b0}};
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         dbz_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         op_div_r <= op_div_s;
         opnd_r   <= opnd_s;
         acc_r    <= acc_s;
         rem_r    <= rem_s;
         hi_r     <= hi_s;
         lo_r     <= lo_s;
         dbz_r    <= dbz_s;
      end
   end

   // Status decode from the state register; stall stays combinational so
   // the hazard unit sees it in the same cycle as start/hilo_rd.
   assign busy        = (state_r == ST_RUN);
   assign done        = (state_r == ST_DONE);
   assign stall       = busy & (start | hilo_rd);
   assign div_by_zero = dbz_r;
   assign hi          = hi_r;
   assign lo          = lo_r;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative unsigned multiply/divide sequencer for the Execute stage of the pipelined MIPS32 core. It accepts a MULTU/DIVU request from the E stage and runs a WIDTH-iteration shift-add multiply or restoring divide. It owns the HI/LO registers and drives a stall request into the hazard unit while a result is pending and the pipeline needs it.

## Interface
Parameters:
- WIDTH, default 32: operand width; HI/LO width; iteration count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  qualified mul/div request from E stage (muldiv_enE_qual)
- mul0_div1_sel  in  1  0 = MULTU, 1 = DIVU; sampled with start
- src_a  in  WIDTH  multiplicand / dividend; sampled with start
- src_b  in  WIDTH  multiplier / divisor; sampled with start
- hilo_rd  in  1  MFHI/MFLO present in E stage
- busy  out  1  iteration in progress
- stall  out  1  hold F/D/E and bubble M (combinational)
- done  out  1  one-cycle pulse; HI/LO just updated
- div_by_zero  out  1  sticky flag for last op; set on DIVU with src_b = 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, DONE. 6-bit iteration counter cnt, used for WIDTH ≤ 63.
- IDLE or DONE with start=1: latch the operands and the op. Clear div_by_zero. Set cnt=0.
  - DIVU with src_b=0: go directly to DONE. hi←src_a, lo←all ones, div_by_zero←1.
  - Otherwise go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN: perform one iteration per cycle and increment cnt. When cnt=WIDTH-1, the final iteration writes hi/lo and the state goes to DONE.
- MULTU: unsigned shift-add. Accumulator is 2·WIDTH bits. Result is {hi,lo} = src_a·src_b with the full product and no overflow.
- DIVU: unsigned restoring division. Partial remainder is WIDTH+1 bits. lo=quotient, hi=remainder.
- start in RUN is ignored and not latched. The hazard unit keeps the instruction held via stall, and it re-presents start once busy falls.
- hi/lo hold their value between completions. Only the final iteration or the div-by-zero path writes them.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - stall = busy & (start | hilo_rd).
- Reset (rst=0 at any edge, including mid-RUN): state←IDLE, cnt←0, hi←0, lo←0, div_by_zero←0. The operation in progress is aborted and no done is generated.

## Timing
- Reset values: busy=0, stall=0, done=0, div_by_zero=0, hi=0, lo=0.
- Normal op: start sampled at edge k. busy=1 for cycles k+1 … k+WIDTH. hi/lo are valid and done=1 in cycle k+WIDTH+1. Latency is WIDTH+1 edges from start to done.
- Div-by-zero: start at edge k. done=1 and hi/lo are valid in cycle k+1. busy never asserts.
- Back-to-back: start held high during the done cycle is accepted at that edge, so there is no idle gap.
- A MFHI/MFLO that reaches E during the done cycle reads the new hi/lo. There is no bypass from the in-flight accumulator.
- stall is combinational from busy, start and hilo_rd, with no added register delay. It deasserts in the done cycle.

## Test plan
- MULTU 7×6: start at edge 0 → busy cycles 1–32; done in cycle 33 with hi=0x00000000, lo=0x0000002A.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; div_by_zero=0.
- DIVU 100/7 → lo=14, hi=2 after 33 edges. DIVU 5/0 → done next cycle, hi=5, lo=0xFFFFFFFF, div_by_zero=1; next valid op clears div_by_zero.
- hilo_rd=1 held from cycle 3 of a MULTU → stall=1 in cycles 3–32 only, 0 in cycle 33; hi/lo are unchanged from the previous result until cycle 33.
- Second start pulsed mid-RUN → ignored. Start held through done → second op begins with no gap; its done arrives 33 edges after the first done.
- rst=0 at cycle 10 of a DIVU → next cycle: busy=0, hi=lo=0, no done pulse; a subsequent MULTU 3×3 gives lo=9.
